// File: rtl/seven_segment_scanner.sv
// Four-digit seven-segment scan controller: steps through the nibbles of a display word
// and swaps in a newly loaded word only at a frame boundary.
module seven_segment_scanner #(
   parameter int unsigned TICKS_PER_DIGIT = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        load_decimal,
   input  logic        load_blank,
   output logic        ready,
   output logic [3:0]  value,
   output logic        decimal,
   output logic [1:0]  digit,
   output logic        blank,
   output logic        frame_done
);

   localparam int unsigned CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICKS_PER_DIGIT - 1);

   typedef struct packed {
      logic [15:0] value;
      logic        decimal;
      logic        blank_en;
   } word_t;

   logic [CW-1:0] tick;
   logic [1:0]    digit_q;
   word_t         disp;
   word_t         shadow;
   logic          pending;
   logic          frame_done_q;
   logic          terminal;
   logic          frame_end;
   logic [15:0]   upper;

   assign terminal  = (tick == TERM);
   assign frame_end = terminal && (digit_q == 2'd3);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick         <= '0;
         digit_q      <= '0;
         disp         <= '0;
         shadow       <= '0;
         pending      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (terminal) begin
            tick    <= '0;
            digit_q <= digit_q + 2'd1;
         end else begin
            tick <= tick + CW'(1);
         end
         frame_done_q <= frame_end;
         // A load arriving in the commit cycle with nothing pending waits a full frame.
         if (frame_end && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
         end else if (load && !pending) begin
            shadow  <= '{value: load_value, decimal: load_decimal, blank_en: load_blank};
            pending <= 1'b1;
         end
      end
   end

   // Nibbles from the current digit upward; all-zero means a leading zero.
   assign upper      = disp.value >> {digit_q, 2'b00};
   assign value      = disp.value[{digit_q, 2'b00} +: 4];
   assign decimal    = disp.decimal;
   assign digit      = digit_q;
   assign blank      = disp.blank_en && (digit_q != 2'd0) && (upper == 16'h0000);
   assign ready      = ~pending;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with four ticks per digit (16-cycle frame).
module tb_seven_segment_scanner;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_value = '0;
   logic        load_decimal = 1'b0;
   logic        load_blank = 1'b0;
   logic        ready;
   logic [3:0]  value;
   logic        decimal;
   logic [1:0]  digit;
   logic        blank;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int n = 0;   // rising edges since reset release; frame position is n % 16

   seven_segment_scanner #(.TICKS_PER_DIGIT(4)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
      .load_decimal(load_decimal), .load_blank(load_blank), .ready(ready),
      .value(value), .decimal(decimal), .digit(digit), .blank(blank),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
      n++;
   endtask

   task automatic goto(input int p);
      do step(); while ((n % 16) != p);
   endtask

   task automatic drive_load(input logic [15:0] v, input logic d, input logic b);
      load = 1'b1; load_value = v; load_decimal = d; load_blank = b;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", value); end
      checks++; if (digit !== 2'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (decimal !== 1'b0) begin errors++; $display("FAIL reset_decimal: got %b expected 0", decimal); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b expected 0", blank); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      reset_n = 1'b1;
      n = 0;
   endtask

   task automatic test_scan();
      for (int k = 0; k < 34; k++) begin
         if (k > 0) step();
         checks++;
         if (digit !== 2'((n % 16) / 4)) begin
            errors++; $display("FAIL scan_digit n=%0d: got %0d expected %0d", n, digit, (n % 16) / 4);
         end
         checks++;
         if (frame_done !== ((n > 0) && (n % 16 == 0))) begin
            errors++; $display("FAIL scan_frame_done n=%0d: got %b expected %b", n, frame_done, (n > 0) && (n % 16 == 0));
         end
      end
   endtask

   task automatic test_load_commit();
      goto(5);
      drive_load(16'h1A2B, 1'b0, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_ready_drop: got %b expected 0", ready); end
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL load_value_early_d1: got %h expected 0", value); end
      goto(15);
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL load_value_early_d3: got %h expected 0", value); end
      step();
      checks++; if (value !== 4'hB) begin errors++; $display("FAIL commit_d0: got %h expected b", value); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL commit_ready: got %b expected 1", ready); end
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL commit_frame_done: got %b expected 1", frame_done); end
      goto(4);
      checks++; if (value !== 4'h2) begin errors++; $display("FAIL commit_d1: got %h expected 2", value); end
      goto(8);
      checks++; if (value !== 4'hA) begin errors++; $display("FAIL commit_d2: got %h expected a", value); end
      goto(12);
      checks++; if (value !== 4'h1) begin errors++; $display("FAIL commit_d3: got %h expected 1", value); end
   endtask

   task automatic test_back_to_back();
      goto(5);
      drive_load(16'h0C3D, 1'b1, 1'b0);
      drive_load(16'hFFFF, 1'b0, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_pending_ready: got %b expected 0", ready); end
      goto(15);
      drive_load(16'hFFFF, 1'b0, 1'b0);
      checks++; if (value !== 4'hD) begin errors++; $display("FAIL b2b_d0: got %h expected d", value); end
      checks++; if (decimal !== 1'b1) begin errors++; $display("FAIL b2b_decimal: got %b expected 1", decimal); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready); end
      goto(4);
      checks++; if (value !== 4'h3) begin errors++; $display("FAIL b2b_d1: got %h expected 3", value); end
      goto(8);
      checks++; if (value !== 4'hC) begin errors++; $display("FAIL b2b_d2: got %h expected c", value); end
      drive_load(16'hFFFF, 1'b0, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_ready: got %b expected 0", ready); end
      goto(12);
      checks++; if (value !== 4'h0 || decimal !== 1'b1) begin errors++; $display("FAIL b2b_old_d3: got %h/%b expected 0/1", value, decimal); end
      goto(0);
      checks++; if (value !== 4'hF) begin errors++; $display("FAIL b2b_new_d0: got %h expected f", value); end
      checks++; if (decimal !== 1'b0) begin errors++; $display("FAIL b2b_new_decimal: got %b expected 0", decimal); end
   endtask

   task automatic test_blank_case(input logic [15:0] w, input logic en, input logic [3:0] exp_mask);
      goto(1);
      drive_load(w, 1'b0, en);
      goto(0);
      for (int d = 0; d < 4; d++) begin
         if (d > 0) goto(4 * d);
         checks++;
         if (blank !== exp_mask[d]) begin
            errors++; $display("FAIL blank_%h_en%b_d%0d: got %b expected %b", w, en, d, blank, exp_mask[d]);
         end
         checks++;
         if (value !== w[4*d +: 4]) begin
            errors++; $display("FAIL blank_value_%h_d%0d: got %h expected %h", w, d, value, w[4*d +: 4]);
         end
      end
   endtask

   task automatic test_blanking();
      test_blank_case(16'h0040, 1'b1, 4'b1100);
      test_blank_case(16'h0000, 1'b1, 4'b1110);
      test_blank_case(16'h0040, 1'b0, 4'b0000);
   endtask

   task automatic test_commit_collision();
      goto(15);
      drive_load(16'h9876, 1'b0, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b expected 0", ready); end
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL coll_old_d0: got %h expected 0", value); end
      goto(4);
      checks++; if (value !== 4'h4) begin errors++; $display("FAIL coll_old_d1: got %h expected 4", value); end
      goto(0);
      checks++; if (value !== 4'h6) begin errors++; $display("FAIL coll_new_d0: got %h expected 6", value); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL coll_new_ready: got %b expected 1", ready); end
      goto(4);
      checks++; if (value !== 4'h7) begin errors++; $display("FAIL coll_new_d1: got %h expected 7", value); end
   endtask

   task automatic test_reset_pending();
      goto(2);
      drive_load(16'h1234, 1'b1, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstp_pending: got %b expected 0", ready); end
      goto(6);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL rstp_value: got %h expected 0", value); end
      checks++; if (digit !== 2'd0) begin errors++; $display("FAIL rstp_digit: got %0d expected 0", digit); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstp_ready: got %b expected 1", ready); end
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      repeat (3) step();
      checks++; if (digit !== 2'd0) begin errors++; $display("FAIL rstp_tick3_digit: got %0d expected 0", digit); end
      step();
      checks++; if (digit !== 2'd1) begin errors++; $display("FAIL rstp_tick4_digit: got %0d expected 1", digit); end
      goto(0);
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL rstp_no_commit: got %h expected 0", value); end
      checks++; if (decimal !== 1'b0) begin errors++; $display("FAIL rstp_decimal: got %b expected 0", decimal); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstp_ready_after: got %b expected 1", ready); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load_commit();
      test_back_to_back();
      test_blanking();
      test_commit_collision();
      test_reset_pending();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
